// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide controller:
// op codes, controller state type and divider iteration count.
package muldiv_pkg;

  localparam logic [4:0] OP_MUL    = 5'b00001;
  localparam logic [4:0] OP_MULH   = 5'b00101;
  localparam logic [4:0] OP_MULHU  = 5'b01001;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_DIV    = 5'b10001;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b11001;
  localparam logic [4:0] OP_REMU   = 5'b11101;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider: load on start, 32 iterations, then done while the
// sign-fixed result is presented. MULDIV_EARLY_OUT_EN skips iteration for /0 and overflow.
module muldiv_div_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        kill,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  localparam int CW = $clog2(DIV_ITERS);

  logic          run, fix, neg_q, neg_r, dz, ovf;
  logic [CW-1:0] cnt;
  logic [31:0]   q, r, d, a_raw, a_mag, b_mag;
  logic [32:0]   sub;
  logic          dz_in, ovf_in;

  assign a_mag  = (is_signed && dividend[31]) ? -dividend : dividend;
  assign b_mag  = (is_signed && divisor[31])  ? -divisor  : divisor;
  assign dz_in  = (divisor == 32'h0);
  assign ovf_in = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
  // bit 32 is the borrow: set when the shifted remainder is below the divisor
  assign sub    = {r, q[31]} - {1'b0, d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0; fix <= 1'b0; cnt <= '0;
      q <= '0; r <= '0; d <= '0; a_raw <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; dz <= 1'b0; ovf <= 1'b0;
    end else if (kill) begin
      run <= 1'b0; fix <= 1'b0;
    end else if (start) begin
      q     <= a_mag;
      r     <= '0;
      d     <= b_mag;
      a_raw <= dividend;
      neg_q <= is_signed && (dividend[31] ^ divisor[31]);
      neg_r <= is_signed && dividend[31];
      dz    <= dz_in;
      ovf   <= ovf_in;
      cnt   <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      run   <= !(dz_in || ovf_in);
      fix   <= dz_in || ovf_in;
`else
      run   <= 1'b1;
      fix   <= 1'b0;
`endif
    end else if (run) begin
      if (!sub[32]) begin
        r <= sub[31:0];
        q <= {q[30:0], 1'b1};
      end else begin
        r <= {r[30:0], q[31]};
        q <= {q[30:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
      if (cnt == CW'(DIV_ITERS - 1)) begin
        run <= 1'b0;
        fix <= 1'b1;
      end
    end else begin
      fix <= 1'b0;
    end
  end

  // Special cases override the iterated values so both builds agree
  assign done = fix;
  assign quot = dz ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : neg_q ? -q : q;
  assign rem  = dz ? a_raw         : ovf ? 32'h0         : neg_r ? -r : r;

endmodule

// File: rtl/muldiv_ctrl.sv
// Single-operation M-extension controller: multiply pipeline of MUL_STAGES and an
// iterative divider sub-core. Optional MULDIV_EARLY_OUT_EN shortens special-case divides.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_tag,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic [4:0]  resp_tag,
  output logic        busy
);

  state_e                state;
  logic [4:0]            op_r, tag_r;
  logic [31:0]           a_r, b_r;
  logic [MUL_STAGES-1:0] vld_q;
  logic [MUL_STAGES:0]   vld_pipe;
  logic                  accept, is_div, mul_go, div_go;
  logic                  a_sgn, b_sgn;
  logic [63:0]           a_ext, b_ext, prod;
  logic [31:0]           mul_res, div_q, div_r;
  logic                  div_done;

  assign is_div = req_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign accept = req_valid && req_ready && !flush && req_op[0];
  assign mul_go = accept && !is_div;
  assign div_go = accept && is_div;

  // vld_pipe[0] is the accept cycle; vld_pipe[MUL_STAGES] marks the result edge
  assign vld_pipe = {vld_q, mul_go};

  // Low 64 bits of the product are sign-agnostic once operands are extended
  assign a_sgn   = op_r inside {OP_MULH, OP_MULHSU};
  assign b_sgn   = (op_r == OP_MULH);
  assign a_ext   = {{32{a_sgn & a_r[31]}}, a_r};
  assign b_ext   = {{32{b_sgn & b_r[31]}}, b_r};
  assign prod    = a_ext * b_ext;
  assign mul_res = (op_r == OP_MUL) ? prod[31:0] : prod[63:32];

  muldiv_div_core u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_go),
    .kill      (flush),
    .dividend  (req_a),
    .divisor   (req_b),
    .is_signed (req_op inside {OP_DIV, OP_REM}),
    .done      (div_done),
    .quot      (div_q),
    .rem       (div_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_tag    <= '0;
      busy        <= 1'b0;
      op_r        <= '0;
      tag_r       <= '0;
      a_r         <= '0;
      b_r         <= '0;
      vld_q       <= '0;
    end else begin
      vld_q <= flush ? '0 : vld_pipe[MUL_STAGES-1:0];
      if (flush) begin
        state      <= IDLE;
        req_ready  <= 1'b1;
        resp_valid <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            op_r      <= req_op;
            a_r       <= req_a;
            b_r       <= req_b;
            tag_r     <= req_tag;
            state     <= is_div ? DIV : MUL;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
          MUL: if (vld_pipe[MUL_STAGES]) begin
            resp_result <= mul_res;
            resp_tag    <= tag_r;
            resp_valid  <= 1'b1;
            state       <= DONE;
          end
          DIV: if (div_done) begin
            resp_result <= (op_r inside {OP_REM, OP_REMU}) ? div_r : div_q;
            resp_tag    <= tag_r;
            resp_valid  <= 1'b1;
            state       <= DONE;
          end
          DONE: if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: scoreboard of expected results/tags, latency,
// stall, flush and reset checks. Latency of special divides follows MULDIV_EARLY_OUT_EN.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, flush = 1'b0, resp_ready = 1'b0;
  logic [4:0]  req_op = '0, req_tag = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_ready, resp_valid, busy;
  logic [31:0] resp_result;
  logic [4:0]  resp_tag;

  int checks = 0, failures = 0;
  logic [36:0] sb[$];

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_tag(resp_tag), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] res);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    sb.push_back({tag, res});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Wait for the response, check latency and payload, optionally stall, then consume
  task automatic get(input string tag, input int lat, input int hold);
    int n = 0;
    logic [36:0] e = '0;
    while (resp_valid !== 1'b1 && n < 100) begin
      @(posedge clk); n++; #1;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    if (sb.size() > 0) e = sb.pop_front();
    chk({tag, "_result"}, resp_result, e[31:0]);
    chk({tag, "_tag"}, 32'(resp_tag), 32'(e[36:32]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_hold_result"}, resp_result, e[31:0]);
      chk({tag, "_hold_tag"}, 32'(resp_tag), 32'(e[36:32]));
      chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
      chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk({tag, "_consumed_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_consumed_busy"}, 32'(busy), 32'd0);
    chk({tag, "_consumed_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic quiet(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_result", resp_result, 32'd0);
    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    send(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB);          get("mul", 2, 0);
    send(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE); get("mulhu", 2, 0);
    send(OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000); get("mulh", 2, 0);
    send(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF); get("mulhsu", 2, 0);

    send(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD);  get("div", 33, 0);
    send(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF);  get("rem", 33, 0);
    send(OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14);              get("divu", 33, 0);
    send(OP_REMU, 32'd100, 32'd7, 5'd10, 32'd2);              get("remu", 33, 0);

    send(OP_DIVU, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF);                   get("divu_zero", EO_LAT, 0);
    send(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);            get("rem_ovf", EO_LAT, 0);
    send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);    get("div_ovf", EO_LAT, 0);
    send(OP_DIV, 32'hFFFF_FFF7, 32'd0, 5'd14, 32'hFFFF_FFFF);            get("div_neg_zero", EO_LAT, 0);
    send(OP_REM, 32'hFFFF_FFF7, 32'd0, 5'd15, 32'hFFFF_FFF7);            get("rem_neg_zero", EO_LAT, 0);

    // op[0] clear: ignored
    @(negedge clk); req_valid = 1'b1; req_op = 5'b10000;
    @(posedge clk); #1 req_valid = 1'b0;
    chk("ignored_busy", 32'(busy), 32'd0);
    chk("ignored_req_ready", 32'(req_ready), 32'd1);

    // flush in IDLE blocks acceptance
    @(negedge clk); req_valid = 1'b1; req_op = OP_MUL; flush = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", 32'(busy), 32'd0);
    quiet("idle_flush_no_resp", 4);

    send(OP_MUL, 32'd6, 32'd7, 5'd16, 32'd42); get("stall", 2, 10);

    // flush at divide iteration 15
    send(OP_DIV, 32'd1000, 32'd3, 5'd17, 32'd333);
    void'(sb.pop_back());
    repeat (15) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("div_flush_busy", 32'(busy), 32'd0);
    chk("div_flush_req_ready", 32'(req_ready), 32'd1);
    chk("div_flush_valid", 32'(resp_valid), 32'd0);
    quiet("div_flush_no_resp", 40);
    send(OP_MUL, 32'd3, 32'd5, 5'd18, 32'd15); get("mul_after_flush", 2, 0);

    // flush in DONE beats resp_ready
    send(OP_MUL, 32'd2, 32'd2, 5'd19, 32'd4);
    void'(sb.pop_back());
    repeat (2) @(posedge clk);
    #1 chk("done_before_flush", 32'(resp_valid), 32'd1);
    @(negedge clk); flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1 flush = 1'b0; resp_ready = 1'b0;
    chk("done_flush_valid", 32'(resp_valid), 32'd0);
    chk("done_flush_busy", 32'(busy), 32'd0);

    // asynchronous reset mid-divide
    send(OP_DIV, 32'd100, 32'd7, 5'd20, 32'd14);
    void'(sb.pop_back());
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_resp_result", resp_result, 32'd0);
    chk("arst_resp_tag", 32'(resp_tag), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    quiet("arst_no_resp", 40);
    send(OP_MUL, 32'd9, 32'd9, 5'd21, 32'd81); get("mul_after_rst", 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
